// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised pipeline stage register with a valid/ready
// handshake, a 2-entry skid buffer for stall back-pressure, and a
// synchronous flush that turns the stage into a bubble.
// Optional statistics counters are enabled by defining PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf #(
  parameter int                 CTRL_W   = 10,
  parameter int                 DATA_W   = 128,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_drops
`endif
);

  // EMPTY: nothing held; ONE: main holds a beat; FULL: main and skid hold beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            stateReg;
  state_t            stateNext;
  logic [CTRL_W-1:0] mainCtrlReg;
  logic [DATA_W-1:0] mainDataReg;
  logic [CTRL_W-1:0] skidCtrlReg;
  logic [DATA_W-1:0] skidDataReg;

  logic mainValid;
  logic skidValid;
  logic inFire;
  logic outFire;
  logic loadMainIn;
  logic loadMainSkid;
  logic loadSkid;

  // Valid bits follow directly from the state encoding; in_ready depends on
  // state only so there is no combinational path from out_ready.
  assign mainValid = (stateReg == ONE) || (stateReg == FULL);
  assign skidValid = (stateReg == FULL);
  assign in_ready  = (stateReg != FULL);
  assign inFire    = in_valid & in_ready;
  assign outFire   = mainValid & out_ready;

  assign out_valid = mainValid;
  assign out_ctrl  = mainValid ? mainCtrlReg : CTRL_NOP;
  assign out_data  = mainDataReg;

  // Next-state and register-load decode; flush overrides every transition.
  always_comb begin
    stateNext    = stateReg;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (stateReg)
      EMPTY: begin
        if (inFire) begin
          stateNext  = ONE;
          loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          loadMainIn = 1'b1;
        end else if (inFire) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
        end else if (outFire) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (outFire) begin
          stateNext    = ONE;
          loadMainSkid = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Squashed beats are simply forgotten; data registers may keep stale values.
    if (flush) begin
      stateNext    = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  // State and payload registers; reset clears everything so outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= EMPTY;
      mainCtrlReg <= '0;
      mainDataReg <= '0;
      skidCtrlReg <= '0;
      skidDataReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (loadMainIn) begin
        mainCtrlReg <= in_ctrl;
        mainDataReg <= in_data;
      end else if (loadMainSkid) begin
        mainCtrlReg <= skidCtrlReg;
        mainDataReg <= skidDataReg;
      end
      if (loadSkid) begin
        skidCtrlReg <= in_ctrl;
        skidDataReg <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [1:0]  dropCount;
  logic [16:0] dropSum;

  // Beats destroyed by a flush: a main beat not taken downstream this cycle,
  // the skid beat, and an incoming beat accepted in the flush cycle.
  always_comb begin
    dropCount = 2'd0;
    if (flush) begin
      dropCount = {1'b0, mainValid & ~outFire} + {1'b0, skidValid} + {1'b0, inFire};
    end
    dropSum = {1'b0, flush_drops} + {15'd0, dropCount};
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (mainValid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      flush_drops <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end
  end
`endif

endmodule
